// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch stage: PC, single-outstanding ibus fetch, 2-entry output queue
// Handles hold backpressure and jump redirect, discarding fetches made stale by a jump.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] INST_NOP = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        jump,
  input  logic [31:0] jump_addr,
  output logic        ibus_req,
  output logic [31:0] ibus_addr,
  input  logic        ibus_gnt,
  input  logic        ibus_rvalid,
  input  logic [31:0] ibus_rdata,
  output logic [31:0] inst_o,
  output logic [31:0] addr_o,
  output logic        valid_o
);

  typedef enum logic [1:0] {IDLE, WAIT, FLUSH} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] req_pc, req_pc_nxt;
  logic [31:0] q_inst [2];
  logic [31:0] q_addr [2];
  logic        head;
  logic        tail;
  logic [1:0]  count;
  logic        pop, push, still_out, credit_ok, req_c;
  logic [2:0]  next_occ;

  assign valid_o = (count != 2'd0);
  assign inst_o  = valid_o ? q_inst[head] : INST_NOP;
  assign addr_o  = valid_o ? q_addr[head] : 32'h0;
  // With at most two entries, the free slot sits at head+count (mod 2).
  assign tail    = head ^ count[0];

  always_comb begin
    pop       = valid_o && !hold && !jump;
    push      = (state == WAIT) && ibus_rvalid && !jump;
    still_out = (state != IDLE) && !ibus_rvalid;
    next_occ  = {1'b0, count} - {2'b00, pop} + {2'b00, push};
    credit_ok = (next_occ + {2'b00, still_out}) < 3'd2;
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    req_pc_nxt = req_pc;
    req_c      = 1'b0;
    if (jump) begin
      pc_nxt = jump_addr & 32'hFFFF_FFFC;
      // A request still owed by memory must be drained before fetching again.
      if ((state != IDLE) && !ibus_rvalid) state_nxt = FLUSH;
      else                                 state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          req_c = credit_ok;
          if (credit_ok && ibus_gnt) begin
            req_pc_nxt = pc;
            pc_nxt     = pc + 32'd4;
            state_nxt  = WAIT;
          end
        end
        WAIT: begin
          if (ibus_rvalid) begin
            req_c = credit_ok;
            if (credit_ok && ibus_gnt) begin
              req_pc_nxt = pc;
              pc_nxt     = pc + 32'd4;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
        FLUSH: begin
          if (ibus_rvalid) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign ibus_req  = req_c && !rst;
  assign ibus_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
      head   <= 1'b0;
      count  <= 2'd0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      req_pc <= req_pc_nxt;
      if (jump) begin
        head  <= 1'b0;
        count <= 2'd0;
      end else begin
        if (pop) head <= ~head;
        count <= next_occ[1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      q_inst[tail] <= ibus_rdata;
      q_addr[tail] <= req_pc;
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - scoreboard bench for ifu_fetch with a latency-configurable memory model
// Stimulus pushes expected fetch addresses; a negedge monitor pops and compares consumed heads.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hold = 1'b0;
  logic        jump = 1'b0;
  logic [31:0] jump_addr = 32'h0;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_gnt = 1'b1;
  logic        ibus_rvalid = 1'b0;
  logic [31:0] ibus_rdata = 32'h0;
  logic [31:0] inst_o;
  logic [31:0] addr_o;
  logic        valid_o;

  int checks = 0;
  int errors = 0;
  int consumed = 0;
  int lat = 1;

  logic [31:0] exp_q [$];

  ifu_fetch #(.RESET_PC(32'h0000_0000), .INST_NOP(32'h0000_0013)) dut (
    .clk(clk), .rst(rst), .hold(hold), .jump(jump), .jump_addr(jump_addr),
    .ibus_req(ibus_req), .ibus_addr(ibus_addr), .ibus_gnt(ibus_gnt),
    .ibus_rvalid(ibus_rvalid), .ibus_rdata(ibus_rdata),
    .inst_o(inst_o), .addr_o(addr_o), .valid_o(valid_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_progress(input string name, input int start, input int min_n);
    checks++;
    if (consumed - start < min_n) begin
      errors++;
      $display("FAIL %s: consumed %0d expected at least %0d", name, consumed - start, min_n);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    logic [31:0] a;
    a = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(a);
      a = a + 32'd4;
    end
  endtask

  // Memory model: acceptance sampled mid-cycle, response after lat cycles; reset kills it.
  logic        acc_q = 1'b0;
  logic        kill = 1'b0;
  logic [31:0] acc_addr = 32'h0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  int          pend_cnt = 0;

  always @(negedge clk) begin
    acc_q    = ibus_req && ibus_gnt && !rst;
    acc_addr = ibus_addr;
    kill     = rst;
    if (acc_q && pend) begin
      errors++;
      checks++;
      $display("FAIL one_outstanding: second request at %h while %h pending", ibus_addr, pend_addr);
    end
  end

  always @(posedge clk) begin
    #1;
    ibus_rvalid = 1'b0;
    if (kill) pend = 1'b0;
    else if (acc_q) begin
      pend      = 1'b1;
      pend_addr = acc_addr;
      pend_cnt  = lat;
    end
    if (pend) begin
      if (pend_cnt <= 1) begin
        ibus_rvalid = 1'b1;
        ibus_rdata  = mem_data(pend_addr);
        pend        = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
  end

  // Scoreboard monitor: a head is consumed when valid_o=1 and hold=0 (jump/rst flush instead).
  always @(negedge clk) begin
    if (!rst && !jump && valid_o && !hold) begin
      if (exp_q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL sb_empty: unexpected output addr %h", addr_o);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("sb_addr", addr_o, e);
        chk("sb_inst", inst_o, mem_data(e));
        consumed++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int start;
    int nreq;
    logic [31:0] frozen;
    logic found;

    // Reset state
    tick();
    @(negedge clk);
    chk("rst_valid", valid_o, 0);
    chk("rst_inst", inst_o, 32'h0000_0013);
    chk("rst_addr", addr_o, 0);
    chk("rst_req", ibus_req, 0);
    tick();
    rst = 1'b0;
    push_seq(32'h0, 40);
    @(negedge clk);
    chk("first_req", ibus_req, 1);
    chk("first_addr", ibus_addr, 32'h0);

    // Streaming at one instruction per cycle
    start = consumed;
    tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      @(negedge clk);
      chk("stream_valid", valid_o, 1);
    end

    // Hold backpressure
    tick();
    hold = 1'b1;
    nreq = 0;
    @(negedge clk);
    frozen = addr_o;
    chk("hold_valid", valid_o, 1);
    if (ibus_req && ibus_gnt) nreq++;
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      chk("hold_valid", valid_o, 1);
      chk("hold_addr", addr_o, frozen);
      if (ibus_req && ibus_gnt) nreq++;
    end
    chk("hold_extra_req", (nreq <= 1), 1);
    tick();
    hold = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk_progress("stream_progress", start, 12);

    // Jump with no request in flight (also jump together with hold)
    hold = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    tick();
    jump = 1'b1;
    jump_addr = 32'h0000_0102;
    exp_q.delete();
    push_seq(32'h0000_0100, 30);
    @(negedge clk);
    chk("j1_req", ibus_req, 0);
    tick();
    jump = 1'b0;
    hold = 1'b0;
    @(negedge clk);
    chk("j1_valid", valid_o, 0);
    chk("j1_inst", inst_o, 32'h0000_0013);
    chk("j1_addr_o", addr_o, 0);
    chk("j1_req_after", ibus_req, 1);
    chk("j1_ibus_addr", ibus_addr, 32'h0000_0100);
    start = consumed;
    for (int i = 0; i < 8; i++) tick();
    chk_progress("j1_progress", start, 5);

    // Jump with a request in flight (3-cycle memory)
    lat = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      @(negedge clk);
      if (ibus_req && ibus_gnt) found = 1'b1;
    end
    chk("j2_accept_seen", found, 1);
    tick();
    jump = 1'b1;
    jump_addr = 32'h0000_0200;
    exp_q.delete();
    push_seq(32'h0000_0200, 30);
    @(negedge clk);
    chk("j2_req", ibus_req, 0);
    tick();
    jump = 1'b0;
    @(negedge clk);
    chk("j2_valid", valid_o, 0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      chk("j2_flush_req", ibus_req, 0);
      if (ibus_rvalid) found = 1'b1;
      else begin
        tick();
        @(negedge clk);
      end
    end
    chk("j2_stale_seen", found, 1);
    tick();
    @(negedge clk);
    chk("j2_req_after", ibus_req, 1);
    chk("j2_ibus_addr", ibus_addr, 32'h0000_0200);
    start = consumed;
    for (int i = 0; i < 12; i++) tick();
    chk_progress("j2_progress", start, 2);

    // Wait states and PC wrap
    jump = 1'b1;
    jump_addr = 32'hFFFF_FFF8;
    ibus_gnt = 1'b0;
    lat = 1;
    exp_q.delete();
    push_seq(32'hFFFF_FFF8, 30);
    tick();
    jump = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (ibus_req) found = 1'b1;
      else tick();
    end
    chk("ws_req_seen", found, 1);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        tick();
        @(negedge clk);
      end
      chk("ws_req", ibus_req, 1);
      chk("ws_addr", ibus_addr, 32'hFFFF_FFF8);
    end
    tick();
    ibus_gnt = 1'b1;
    start = consumed;
    for (int i = 0; i < 10; i++) tick();
    chk_progress("wrap_progress", start, 5);

    // Reset while a fetch is outstanding
    lat = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      @(negedge clk);
      if (ibus_req && ibus_gnt) found = 1'b1;
    end
    chk("rs_accept_seen", found, 1);
    tick();
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("rs_req_forced", ibus_req, 0);
    tick();
    rst = 1'b0;
    push_seq(32'h0, 30);
    @(negedge clk);
    chk("rs_valid", valid_o, 0);
    chk("rs_req", ibus_req, 1);
    chk("rs_addr", ibus_addr, 32'h0);
    start = consumed;
    for (int i = 0; i < 12; i++) tick();
    chk_progress("rs_progress", start, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
